// File: rtl/microwave_cook_timer_if.sv
// Keypad/timebase inputs and display/status outputs of the cook timer.
// master drives the key and control lines; slave is the timer itself.
interface microwave_cook_timer_if;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       start;
  logic       clearn;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       zero;
  logic       cooking;
  logic       done;

  modport master (
    output D, loadn, pgt_1Hz, start, clearn,
    input  min_ones, sec_tens, sec_ones, zero, cooking, done
  );

  modport slave (
    input  D, loadn, pgt_1Hz, start, clearn,
    output min_ones, sec_tens, sec_ones, zero, cooking, done
  );
endinterface

// File: rtl/microwave_cook_timer.sv
// BCD M:SS cook-time entry and 1 Hz countdown; a key lands SYNC_STAGES+1 clocks after loadn falls,
// a tick acts SYNC_STAGES+1 clocks after pgt_1Hz rises; no backpressure, events are single-cycle pulses.
module microwave_cook_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  microwave_cook_timer_if.slave bus
);

  typedef enum logic [1:0] {ENTRY, COUNT, DONE} state_t;

  state_t                       state, state_nxt;
  logic [SYNC_STAGES-1:0]       loadn_sync;
  logic [SYNC_STAGES-1:0]       pgt_sync;
  logic [SYNC_STAGES-1:0][3:0]  d_sync;
  logic                         loadn_prev, pgt_prev;
  logic                         load_evt, tick_evt;
  logic [3:0]                   key_d;
  logic [3:0]                   min_ones, sec_tens, sec_ones;
  logic [3:0]                   mo_nxt, st_nxt, so_nxt;
  logic                         zero, zero_nxt, cooking;

  // D rides alongside loadn so the digit and its strobe emerge on the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loadn_sync <= '1;
      pgt_sync   <= '0;
      d_sync     <= '0;
      loadn_prev <= 1'b1;
      pgt_prev   <= 1'b0;
    end else begin
      loadn_sync <= {loadn_sync[SYNC_STAGES-2:0], bus.loadn};
      pgt_sync   <= {pgt_sync[SYNC_STAGES-2:0], bus.pgt_1Hz};
      d_sync     <= {d_sync[SYNC_STAGES-2:0], bus.D};
      loadn_prev <= loadn_sync[SYNC_STAGES-1];
      pgt_prev   <= pgt_sync[SYNC_STAGES-1];
    end
  end

  assign load_evt = loadn_prev & ~loadn_sync[SYNC_STAGES-1];
  assign tick_evt = ~pgt_prev & pgt_sync[SYNC_STAGES-1];
  assign key_d    = d_sync[SYNC_STAGES-1];

  assign zero     = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign zero_nxt = (mo_nxt == 4'd0) && (st_nxt == 4'd0) && (so_nxt == 4'd0);

  always_comb begin
    state_nxt = state;
    mo_nxt    = min_ones;
    st_nxt    = sec_tens;
    so_nxt    = sec_ones;
    if (!bus.clearn) begin
      state_nxt = ENTRY;
      mo_nxt    = 4'd0;
      st_nxt    = 4'd0;
      so_nxt    = 4'd0;
    end else begin
      case (state)
        ENTRY: begin
          if (load_evt && key_d <= 4'd9) begin
            mo_nxt = sec_tens;
            st_nxt = sec_ones;
            so_nxt = key_d;
          end else if (bus.start && !zero) begin
            state_nxt = COUNT;
          end
        end
        COUNT: begin
          if (tick_evt && bus.start && !zero) begin
            // Tens digits 6-9 typed at entry simply count down; only a 0 borrows.
            if (sec_ones != 4'd0) begin
              so_nxt = sec_ones - 4'd1;
            end else begin
              so_nxt = 4'd9;
              if (sec_tens != 4'd0) begin
                st_nxt = sec_tens - 4'd1;
              end else begin
                st_nxt = 4'd5;
                mo_nxt = min_ones - 4'd1;
              end
            end
            if (zero_nxt) state_nxt = DONE;
          end
        end
        DONE: begin
          if (load_evt && key_d <= 4'd9) begin
            state_nxt = ENTRY;
            mo_nxt    = 4'd0;
            st_nxt    = 4'd0;
            so_nxt    = key_d;
          end
        end
        default: state_nxt = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ENTRY;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      cooking  <= 1'b0;
    end else begin
      state    <= state_nxt;
      min_ones <= mo_nxt;
      sec_tens <= st_nxt;
      sec_ones <= so_nxt;
      cooking  <= (state_nxt == COUNT) & bus.start & ~zero_nxt;
    end
  end

  assign bus.min_ones = min_ones;
  assign bus.sec_tens = sec_tens;
  assign bus.sec_ones = sec_ones;
  assign bus.zero     = zero;
  assign bus.cooking  = cooking;
  assign bus.done     = (state == DONE);

endmodule
